uv_scan_counter: RTL and testbench



---
 rtl/dct_pkg.sv | 16 +
 rtl/uv_scan_counter_ff_en.sv | 32 +++
 rtl/uv_scan_counter.sv | 75 +++++++
 tb/tb_uv_scan_counter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared constants and types for the 8x8 block DCT engine.
//
// BLOCK_SIZE  positions per dimension of a block (power of two, >= 2)
// IDX_WIDTH   width of a single coefficient index
// idx_t       one coefficient index (u or v)
// IDX_LAST    highest index value, i.e. the last row/column of a block
package dct_pkg;

  localparam int BLOCK_SIZE = 8;
  localparam int IDX_WIDTH  = $clog2(BLOCK_SIZE);

  typedef logic [IDX_WIDTH-1:0] idx_t;

  localparam idx_t IDX_LAST = idx_t'(BLOCK_SIZE - 1);

endpackage

// File: rtl/uv_scan_counter_ff_en.sv
// Generic enabled register with a synchronous active-low reset.
// The reset value is a runtime port so one module can serve the DCT state
// register, the coefficient output registers and the index counters alike.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset, loads rst_val
//   en       load enable for D
//   rst_val  value taken on reset
//   D        next value
//   Q        registered value
module ff_en #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  // Reset wins over enable; without enable the register simply holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Q <= rst_val;
    end else if (en) begin
      Q <= D;
    end
  end

endmodule

// File: rtl/uv_scan_counter.sv
// Two-level (u, v) coefficient index sequencer for the block DCT engine.
// Walks every position of a BLOCK_SIZE x BLOCK_SIZE block in row-major order
// (u outer, v inner) and flags the final position so the DCT controller can
// leave its calculating state. The sequencer saturates at the last position
// instead of wrapping.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset, index pair goes to (0,0)
//   restart  synchronous clear of the index pair to (0,0), beats go
//   go       advance enable
//   u        outer (row) index, registered
//   v        inner (column) index, registered
//   done     high while the registered pair is the last position
module uv_scan_counter
  import dct_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 restart,
  input  logic                 go,
  output logic [IDX_WIDTH-1:0] u,
  output logic [IDX_WIDTH-1:0] v,
  output logic                 done
);

  idx_t u_next;
  idx_t v_next;

  // Terminal flag is decoded straight from the registered indices so it lines
  // up with the cycle in which (IDX_LAST, IDX_LAST) is presented.
  assign done = (u == IDX_LAST) && (v == IDX_LAST);

  // Next-index logic. The registers load every cycle, so holding is expressed
  // here by feeding back the current value. Gating the advance with done is
  // what makes the scan saturate rather than wrap back to (0,0).
  always_comb begin
    u_next = u;
    v_next = v;
    if (restart) begin
      u_next = '0;
      v_next = '0;
    end else if (go && !done) begin
      if (v == IDX_LAST) begin
        v_next = '0;
        u_next = u + 1'b1;
      end else begin
        v_next = v + 1'b1;
      end
    end
  end

  ff_en #(
    .WIDTH(IDX_WIDTH)
  ) u_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (1'b1),
    .rst_val('0),
    .D      (u_next),
    .Q      (u)
  );

  ff_en #(
    .WIDTH(IDX_WIDTH)
  ) v_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (1'b1),
    .rst_val('0),
    .D      (v_next),
    .Q      (v)
  );

endmodule

// File: tb/tb_uv_scan_counter.sv
// Self-checking bench for uv_scan_counter plus a small unit check of ff_en.
// The reference model tracks the scan as a single linear position 0..N*N-1
// and derives the expected (u, v, done) from it arithmetically.
module tb_uv_scan_counter;

  localparam int N    = 8;
  localparam int LAST = N * N - 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       restart;
  logic       go;
  logic [2:0] u;
  logic [2:0] v;
  logic       done;

  logic       ff_rst_n;
  logic       ff_en_in;
  logic [3:0] ff_d;
  logic [3:0] ff_q;

  int pos;
  int check_count = 0;
  int pass_count  = 0;

  always #5 clk = ~clk;

  uv_scan_counter dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(restart),
    .go     (go),
    .u      (u),
    .v      (v),
    .done   (done)
  );

  ff_en #(
    .WIDTH(4)
  ) ff_dut (
    .clk    (clk),
    .rst_n  (ff_rst_n),
    .en     (ff_en_in),
    .rst_val(4'hA),
    .D      (ff_d),
    .Q      (ff_q)
  );

  // Drive one cycle of inputs, let a rising edge happen, advance the model
  // and leave the bench 1 time unit after the edge for sampling.
  task automatic applyStimulus(input logic r, input logic rs, input logic g);
    rst_n   = r;
    restart = rs;
    go      = g;
    @(posedge clk);
    if (!r || rs) begin
      pos = 0;
    end else if (g && pos < LAST) begin
      pos = pos + 1;
    end
    #1;
  endtask

  task automatic checkOutput(input string tag);
    logic [2:0] exp_u;
    logic [2:0] exp_v;
    logic       exp_done;
    exp_u    = 3'(pos / N);
    exp_v    = 3'(pos % N);
    exp_done = (pos == LAST);
    check_count++;
    assert (u === exp_u) pass_count++;
    else $error("[TB] FAIL %s u: got %0d want %0d", tag, u, exp_u);
    check_count++;
    assert (v === exp_v) pass_count++;
    else $error("[TB] FAIL %s v: got %0d want %0d", tag, v, exp_v);
    check_count++;
    assert (done === exp_done) pass_count++;
    else $error("[TB] FAIL %s done: got %b want %b", tag, done, exp_done);
  endtask

  task automatic checkFf(input string tag, input logic [3:0] expected);
    check_count++;
    assert (ff_q === expected) pass_count++;
    else $error("[TB] FAIL %s Q: got %h want %h", tag, ff_q, expected);
  endtask

  // Advance with go held until the model reaches the requested position.
  task automatic advanceTo(input int target, input string tag);
    for (int i = 0; i < N * N && pos != target; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput(tag);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    restart  = 1'b0;
    go       = 1'b1;
    ff_rst_n = 1'b0;
    ff_en_in = 1'b0;
    ff_d     = 4'h0;
    pos      = 0;

    // Reset with go high, then release with go low and watch it hold.
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("reset");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("reset_hold");
    end

    // Full scan plus one extra edge to show saturation at the last position.
    for (int k = 1; k <= N * N; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput(k == N * N ? "saturate" : "scan");
    end
    if (pos != LAST) $display("[TB] note: model not at last position");

    // Row wrap from (2,7) to (3,0).
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("restart_to_wrap");
    advanceTo(2 * N + 7, "to_2_7");
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("row_wrap");

    // Pause at (4,5) for three cycles, then resume.
    advanceTo(4 * N + 5, "to_4_5");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("pause");
    end
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("resume");

    // Restart beats go mid-scan, and clears done at the last position.
    advanceTo(6 * N + 3, "to_6_3");
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("restart_mid");
    advanceTo(LAST, "to_last");
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("restart_last");

    // Reset mid-scan.
    advanceTo(20, "to_20");
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("reset_mid");

    // Randomised control traffic against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 31) != 0),
                    ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 3) != 0));
      checkOutput("random");
    end

    // ff_en unit checks with rst_val = A.
    ff_rst_n = 1'b0; ff_en_in = 1'b0; ff_d = 4'h0;
    @(posedge clk); #1;
    checkFf("ff_reset", 4'hA);
    ff_rst_n = 1'b1; ff_en_in = 1'b1; ff_d = 4'h5;
    @(posedge clk); #1;
    checkFf("ff_load", 4'h5);
    ff_en_in = 1'b0; ff_d = 4'h3;
    @(posedge clk); #1;
    checkFf("ff_hold", 4'h5);
    ff_rst_n = 1'b0; ff_en_in = 1'b1; ff_d = 4'h3;
    @(posedge clk); #1;
    checkFf("ff_reset_over_en", 4'hA);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
